// File: rtl/qspi_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qspi_arb : round-robin i/d/x arbiter with write-back priority and watchdog
//            in front of a QSPI line-transfer engine.      Rev 1.0
// ---------------------------------------------------------------------------
module qspi_arb #(
  parameter int PA          = 24,
  parameter int LINE_LENGTH = 4,
  parameter int TIMEOUT     = 255,
  localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  input  logic          x_req,
  input  logic          x_write,
  input  logic [TW-1:0] x_tag,
  input  logic [1:0]    i_mem,
  input  logic [1:0]    d_mem,
  input  logic [1:0]    x_mem,
  output logic          i_grant,
  output logic          d_grant,
  output logic          x_grant,
  output logic          i_done,
  output logic          d_done,
  output logic          x_done,
  output logic          err,
  output logic          q_req,
  output logic          q_write,
  output logic          q_i_d,
  output logic [1:0]    q_mem,
  output logic [TW-1:0] q_paddr,
  input  logic          q_done,
  output logic          busy
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_XFER    = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;
  localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    done_q, done_d;
  logic [2:0]    last_q, last_d;
  logic          push_q, push_d;
  logic          err_q, err_d;
  logic [7:0]    wd_q, wd_d;
  logic          wr_q, wr_d;
  logic          iside_q, iside_d;
  logic [1:0]    mem_q, mem_d;
  logic [TW-1:0] paddr_q, paddr_d;

  logic [2:0]    w_sel;
  logic          w_sel_write;
  logic [1:0]    w_sel_mem;
  logic [TW-1:0] w_sel_tag;
  logic          w_wd_expire;

  assign w_wd_expire = (wd_q == c_WD_LAST);

  // A pending push beats rotation unless the last grant was itself a push.
  always_comb begin
    w_sel = 3'b000;
    if (d_req && d_write && !push_q) begin
      w_sel = 3'b010;
    end else begin
      case (last_q)
        3'b001: begin
          if (d_req)      w_sel = 3'b010;
          else if (x_req) w_sel = 3'b100;
          else if (i_req) w_sel = 3'b001;
        end
        3'b010: begin
          if (x_req)      w_sel = 3'b100;
          else if (i_req) w_sel = 3'b001;
          else if (d_req) w_sel = 3'b010;
        end
        default: begin
          if (i_req)      w_sel = 3'b001;
          else if (d_req) w_sel = 3'b010;
          else if (x_req) w_sel = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_mem   = i_mem;
    w_sel_tag   = i_tag;
    if (w_sel[1]) begin
      w_sel_write = d_write;
      w_sel_mem   = d_mem;
      w_sel_tag   = d_tag;
    end else if (w_sel[2]) begin
      w_sel_write = x_write;
      w_sel_mem   = x_mem;
      w_sel_tag   = x_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:    if (|w_sel) state_d = c_XFER;
      c_XFER:    if (q_done || w_wd_expire) state_d = c_RELEASE;
      c_RELEASE: state_d = c_IDLE;
      default:   state_d = c_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    done_d  = 3'b000;
    err_d   = 1'b0;
    wd_d    = wd_q;
    last_d  = last_q;
    push_d  = push_q;
    wr_d    = wr_q;
    iside_d = iside_q;
    mem_d   = mem_q;
    paddr_d = paddr_q;
    case (state_q)
      c_IDLE: begin
        if (|w_sel) begin
          grant_d = w_sel;
          wd_d    = 8'd0;
          last_d  = w_sel;
          push_d  = w_sel[1] & w_sel_write;
          wr_d    = w_sel_write;
          iside_d = w_sel[0];
          mem_d   = w_sel_mem;
          paddr_d = w_sel_tag;
        end
      end
      c_XFER: begin
        // q_done outranks a watchdog expiry in the same cycle.
        if (q_done) begin
          done_d = grant_q;
        end else if (w_wd_expire) begin
          done_d = grant_q;
          err_d  = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      c_RELEASE: grant_d = 3'b000;
      default:   grant_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= 3'b000;
      done_q  <= 3'b000;
      err_q   <= 1'b0;
      wd_q    <= 8'd0;
      last_q  <= 3'b100;
      push_q  <= 1'b0;
      wr_q    <= 1'b0;
      iside_q <= 1'b0;
      mem_q   <= 2'd0;
      paddr_q <= '0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      push_q  <= push_d;
      wr_q    <= wr_d;
      iside_q <= iside_d;
      mem_q   <= mem_d;
      paddr_q <= paddr_d;
    end
  end

  assign i_grant = grant_q[0];
  assign d_grant = grant_q[1];
  assign x_grant = grant_q[2];
  assign i_done  = done_q[0];
  assign d_done  = done_q[1];
  assign x_done  = done_q[2];
  assign err     = err_q;
  assign q_req   = (state_q == c_XFER);
  assign q_write = wr_q;
  assign q_i_d   = iside_q;
  assign q_mem   = mem_q;
  assign q_paddr = paddr_q;
  assign busy    = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qspi_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qspi_arb : directed bench for qspi_arb (TIMEOUT=10).      Rev 1.0
// ---------------------------------------------------------------------------
module tb_qspi_arb;

  localparam int TW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_write, x_req, x_write, q_done;
  logic [TW-1:0] i_tag, d_tag, x_tag;
  logic [1:0]    i_mem, d_mem, x_mem;
  logic          i_grant, d_grant, x_grant, i_done, d_done, x_done, err;
  logic          q_req, q_write, q_i_d, busy;
  logic [1:0]    q_mem;
  logic [TW-1:0] q_paddr;

  int n_cmp = 0;
  int n_bad = 0;

  qspi_arb #(.PA(24), .LINE_LENGTH(4), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_tag(i_tag),
    .d_req(d_req), .d_write(d_write), .d_tag(d_tag),
    .x_req(x_req), .x_write(x_write), .x_tag(x_tag),
    .i_mem(i_mem), .d_mem(d_mem), .x_mem(x_mem),
    .i_grant(i_grant), .d_grant(d_grant), .x_grant(x_grant),
    .i_done(i_done), .d_done(d_done), .x_done(x_done),
    .err(err), .q_req(q_req), .q_write(q_write), .q_i_d(q_i_d),
    .q_mem(q_mem), .q_paddr(q_paddr), .q_done(q_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts in an IDLE cycle with requests set; ends in the following IDLE cycle.
  task automatic xfer_once(input string tag, input logic [2:0] g, input logic [31:0] pa,
                           input logic wr, input logic [1:0] mem);
    step();
    check({tag, " grant"}, {29'd0, x_grant, d_grant, i_grant}, {29'd0, g});
    check({tag, " q_req"}, {31'd0, q_req}, 32'd1);
    check({tag, " paddr"}, {10'd0, q_paddr}, pa);
    check({tag, " write"}, {31'd0, q_write}, {31'd0, wr});
    check({tag, " q_i_d"}, {31'd0, q_i_d}, {31'd0, g[0]});
    check({tag, " mem"}, {30'd0, q_mem}, {30'd0, mem});
    q_done = 1'b1;
    step();
    q_done = 1'b0;
    check({tag, " done"}, {29'd0, x_done, d_done, i_done}, {29'd0, g});
    check({tag, " rel q_req"}, {31'd0, q_req}, 32'd0);
    check({tag, " rel grant"}, {29'd0, x_grant, d_grant, i_grant}, {29'd0, g});
    check({tag, " rel err"}, {31'd0, err}, 32'd0);
    step();
    check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; q_done = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; x_req = 1'b0; x_write = 1'b0;
    i_tag = '0; d_tag = '0; x_tag = '0; i_mem = 2'd0; d_mem = 2'd0; x_mem = 2'd0;
    step(); step();
    reset = 1'b0;
    check("reset grants", {29'd0, x_grant, d_grant, i_grant}, 32'd0);
    check("reset dones", {29'd0, x_done, d_done, i_done}, 32'd0);
    check("reset ctl", {27'd0, err, q_req, q_write, q_i_d, busy}, 32'd0);
    check("reset mem", {30'd0, q_mem}, 32'd0);
    check("reset paddr", {10'd0, q_paddr}, 32'd0);

    // single icache fill
    i_req = 1'b1; i_tag = 22'h12345; i_mem = 2'd2;
    step();
    check("i grant", {29'd0, x_grant, d_grant, i_grant}, 32'd1);
    check("i q_req", {31'd0, q_req}, 32'd1);
    check("i q_i_d", {31'd0, q_i_d}, 32'd1);
    check("i paddr", {10'd0, q_paddr}, 32'h12345);
    check("i mem", {30'd0, q_mem}, 32'd2);
    i_req = 1'b0;
    q_done = 1'b1;
    step();
    q_done = 1'b0;
    check("i done", {29'd0, x_done, d_done, i_done}, 32'd1);
    check("i rel q_req", {31'd0, q_req}, 32'd0);
    check("i rel grant", {31'd0, i_grant}, 32'd1);
    step();
    check("i idle busy", {31'd0, busy}, 32'd0);
    check("i idle done", {29'd0, x_done, d_done, i_done}, 32'd0);

    // fresh reset, then round-robin with all three pulling
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_tag = 22'h111; d_tag = 22'h222; x_tag = 22'h333;
    i_mem = 2'd1; d_mem = 2'd2; x_mem = 2'd3;
    i_req = 1'b1; d_req = 1'b1; x_req = 1'b1;
    xfer_once("rr1", 3'b001, 32'h111, 1'b0, 2'd1);
    xfer_once("rr2", 3'b010, 32'h222, 1'b0, 2'd2);
    xfer_once("rr3", 3'b100, 32'h333, 1'b0, 2'd3);
    xfer_once("rr4", 3'b001, 32'h111, 1'b0, 2'd1);

    // after an i grant: d pull by rotation, then push beats x, then rotation resumes
    i_req = 1'b0;
    xfer_once("dpull", 3'b010, 32'h222, 1'b0, 2'd2);
    d_write = 1'b1; x_write = 1'b1;
    xfer_once("dpush", 3'b010, 32'h222, 1'b1, 2'd2);
    xfer_once("xafter", 3'b100, 32'h333, 1'b1, 2'd3);
    x_req = 1'b0; d_req = 1'b0; i_req = 1'b1;
    xfer_once("ifill", 3'b001, 32'h111, 1'b0, 2'd1);
    d_req = 1'b1;
    xfer_once("push1", 3'b010, 32'h222, 1'b1, 2'd2);
    xfer_once("nostarve", 3'b001, 32'h111, 1'b0, 2'd1);
    i_req = 1'b0; d_req = 1'b0;

    // stray q_done while idle
    q_done = 1'b1;
    step();
    q_done = 1'b0;
    check("idle qdone done", {29'd0, x_done, d_done, i_done}, 32'd0);
    check("idle qdone busy", {31'd0, busy}, 32'd0);

    // latched fields survive input changes mid-transfer
    d_write = 1'b0; d_tag = 22'h2AB; d_mem = 2'd1; d_req = 1'b1;
    step();
    check("hold grant", {29'd0, x_grant, d_grant, i_grant}, 32'd2);
    d_tag = 22'h3FFFFF; d_req = 1'b0; d_write = 1'b1; d_mem = 2'd3;
    step();
    check("hold paddr", {10'd0, q_paddr}, 32'h2AB);
    check("hold write", {31'd0, q_write}, 32'd0);
    check("hold mem", {30'd0, q_mem}, 32'd1);
    check("hold q_req", {31'd0, q_req}, 32'd1);
    q_done = 1'b1;
    step();
    q_done = 1'b0;
    check("hold done", {29'd0, x_done, d_done, i_done}, 32'd2);
    d_write = 1'b0;
    step();

    // watchdog expiry after 10 XFER cycles
    x_req = 1'b1; x_write = 1'b0;
    step();
    check("wd grant", {29'd0, x_grant, d_grant, i_grant}, 32'd4);
    x_req = 1'b0;
    repeat (9) step();
    check("wd c10 q_req", {31'd0, q_req}, 32'd1);
    check("wd c10 err", {31'd0, err}, 32'd0);
    step();
    check("wd err", {31'd0, err}, 32'd1);
    check("wd done", {29'd0, x_done, d_done, i_done}, 32'd4);
    check("wd q_req", {31'd0, q_req}, 32'd0);
    step();
    check("wd err clr", {31'd0, err}, 32'd0);
    check("wd busy", {31'd0, busy}, 32'd0);

    // q_done on the expiry cycle wins
    i_req = 1'b1;
    step();
    check("tie grant", {29'd0, x_grant, d_grant, i_grant}, 32'd1);
    i_req = 1'b0;
    repeat (9) step();
    q_done = 1'b1;
    step();
    q_done = 1'b0;
    check("tie done", {29'd0, x_done, d_done, i_done}, 32'd1);
    check("tie err", {31'd0, err}, 32'd0);
    step();

    // reset in the middle of a transfer
    d_req = 1'b1;
    step();
    check("rst grant", {29'd0, x_grant, d_grant, i_grant}, 32'd2);
    reset = 1'b1;
    step();
    check("rst q_req", {31'd0, q_req}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst grants", {29'd0, x_grant, d_grant, i_grant}, 32'd0);
    check("rst dones", {29'd0, x_done, d_done, i_done}, 32'd0);
    reset = 1'b0;
    i_req = 1'b1; x_req = 1'b1;
    xfer_once("post rst", 3'b001, 32'h111, 1'b0, 2'd1);
    i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qspi_arb.md
QSPI_ARB -- requirements
Module: qspi_arb

Interface
REQ-001 Parameter PA, default 24, physical address width in bits.
REQ-002 Parameter LINE_LENGTH, default 4, cache line length in bytes; TW = PA - clog2(LINE_LENGTH) is the tag width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles allowed between q_req assertion and q_done; range 1..255.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 i_req  in  1  icache line-fill request, read only.
REQ-007 i_tag  in  TW  icache line address.
REQ-008 d_req, d_write  in  1 each  dcache line request; d_write=1 means push (write-back), 0 means pull.
REQ-009 d_tag  in  TW  dcache line address.
REQ-010 x_req, x_write  in  1 each  auxiliary (loader/debug) line request and direction.
REQ-011 x_tag  in  TW  auxiliary line address.
REQ-012 i_mem, d_mem, x_mem  in  2 each  target chip select code per requester.
REQ-013 i_grant, d_grant, x_grant  out  1 each  one-hot grant; qspi strobes belong to the granted requester.
REQ-014 i_done, d_done, x_done  out  1 each  one-cycle completion pulse to the granted requester.
REQ-015 err  out  1  one-cycle pulse, coincident with the done pulse, when the transfer timed out.
REQ-016 q_req, q_write, q_i_d  out  1 each  request, direction and icache-side flag to the qspi engine.
REQ-017 q_mem  out  2; q_paddr  out  TW  chip select and line address to the qspi engine.
REQ-018 q_done  in  1  qspi engine pulse on the final nibble of a line transfer.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, XFER and RELEASE.
REQ-021 In IDLE with any request asserted, the FSM SHALL select one requester and enter XFER on the next edge; q_req, the matching grant, q_write, q_mem and q_paddr are registered and become valid in that cycle.
REQ-022 Selection SHALL be round-robin in the order i, d, x, starting after the most recently granted requester; after reset, i has first priority.
REQ-023 A pending d_req with d_write=1 SHALL win over any other requester when the previous grant was not a dcache push, so that write-backs are never starved by fills.
REQ-024 The tag, direction and mem fields SHALL be latched at grant and held constant through XFER, regardless of input changes.
REQ-025 q_write SHALL equal the latched write bit; i requests always have write=0; q_i_d=1 only for an i grant.
REQ-026 q_req SHALL stay high throughout XFER; deassertion of the requester's req during XFER SHALL NOT abort the transfer.
REQ-027 On q_done in XFER (cycle M), the FSM SHALL enter RELEASE at M+1 with q_req=0, the grant still high, and the granted requester's done pulsed for exactly that cycle.
REQ-028 RELEASE SHALL always return to IDLE after one cycle; the earliest next grant is M+3.
REQ-029 An 8-bit watchdog SHALL clear on entry to XFER and increment each XFER cycle; when it reaches TIMEOUT without q_done, the FSM SHALL enter RELEASE with done and err pulsed.
REQ-030 If q_done and the timeout occur in the same cycle, q_done SHALL take precedence and err stays 0.
REQ-031 q_done seen outside XFER SHALL be ignored.
REQ-032 At most one grant and at most one done SHALL be high in any cycle.

Reset
REQ-033 Reset SHALL force IDLE, all grants, dones, err, q_req, q_write, q_i_d and busy to 0, q_mem and q_paddr to 0, the watchdog to 0, and the round-robin pointer to favour i; these values are visible in the cycle after reset is sampled.
REQ-034 Reset asserted during XFER SHALL drop q_req on the next edge with no done pulse.

Verification
REQ-035 i_req=1 only, i_tag=0x12345 -> i_grant, q_req, q_i_d=1 and q_paddr=0x12345 one cycle later; q_done at M -> i_done pulse at M+1; busy low at M+2.
REQ-036 i_req, d_req (pull) and x_req held continuously -> grants in order i, d, x, i, each separated by one RELEASE and one IDLE cycle.
REQ-037 After an i grant, i_req and d_req with d_write=1 asserted together -> d_grant next, q_write=1.
REQ-038 TIMEOUT=10, never pulse q_done -> RELEASE after 10 XFER cycles with err=1 and done=1 for the granted requester.
REQ-039 d_tag changed and d_req dropped mid-XFER -> q_paddr unchanged and d_done still pulses on q_done.
REQ-040 Reset pulsed during XFER -> q_req=0 and busy=0 next cycle, no done pulse, and the next grant goes to i.
